// File: rtl/mvm_mac_arb.sv
// mvm_mac_arb: round-robin arbiter that lets NREQ requesters share one MAC
// for signed 8-bit dot products. One job runs at a time: grant, clear the
// accumulator, stream elements, drain the MAC pipeline, then present the result.
// Optional feature macro: MVM_MAC_ARB_OVF_STICKY_EN (sticky overflow per job).
module mvm_mac_arb #(
    parameter int NREQ = 4,
    parameter int OUTW = 4,
    localparam int GW  = $clog2(NREQ)
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [NREQ-1:0]      req_valid_i,
    input  logic [NREQ*8-1:0]    req_a_i,
    input  logic [NREQ*8-1:0]    req_b_i,
    input  logic [NREQ-1:0]      req_last_i,
    output logic [NREQ-1:0]      req_ready_o,
    output logic [7:0]           mac_a_o,
    output logic [7:0]           mac_b_o,
    output logic                 mac_valid_in_o,
    output logic                 mac_clr_o,
    input  logic [15:0]          mac_f_i,
    input  logic                 mac_valid_out_i,
    input  logic                 mac_overflow_i,
    output logic [15:0]          res_data_o,
    output logic [GW-1:0]        res_id_o,
    output logic                 res_overflow_o,
    output logic                 res_valid_o,
    input  logic                 res_ready_i
);

    typedef enum logic [2:0] {IDLE, CLEAR, BURST, DRAIN, RESULT} state_t;

    state_t               state_q, state_d;
    logic [GW-1:0]        grant_q;
    logic [GW-1:0]        rr_ptr_q;
    logic [OUTW-1:0]      cnt_q, cnt_d;
    logic [7:0]           mac_a_q, mac_b_q;
    logic                 mac_vin_q;
    logic [15:0]          res_data_q;
    logic                 res_ovf_q;

    logic [NREQ-1:0][7:0] a_arr, b_arr;
    logic                 pick_found;
    logic [GW-1:0]        pick_idx;
    logic                 xfer;
    logic                 dec;
    logic                 cap;

    assign a_arr = req_a_i;
    assign b_arr = req_b_i;

    // Element handshake with the granted requester, and counted MAC returns.
    assign xfer = (state_q == BURST) && req_valid_i[grant_q];
    assign dec  = mac_valid_out_i && (cnt_q != '0);
    assign cap  = dec && ((state_q == BURST) || (state_q == DRAIN));

    // Round-robin search starting at the slot after the last grant.
    always_comb begin
        logic [GW-1:0] cand;
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = GW'((int'(rr_ptr_q) + k) % NREQ);
            if (!pick_found && req_valid_i[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Outstanding-element count: MAC issues in, MAC returns out.
    always_comb begin
        cnt_d = cnt_q;
        case ({mac_vin_q, dec})
            2'b10:   cnt_d = cnt_q + OUTW'(1);
            2'b01:   cnt_d = cnt_q - OUTW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Next-state logic for the job sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_found) state_d = CLEAR;
            CLEAR:   state_d = BURST;
            BURST:   if (xfer && req_last_i[grant_q]) state_d = DRAIN;
            DRAIN:   if ((cnt_q == '0) && !mac_vin_q) state_d = RESULT;
            RESULT:  if (res_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Combinational handshake outputs; forced low while reset is held.
    always_comb begin
        req_ready_o = '0;
        mac_clr_o   = 1'b0;
        res_valid_o = 1'b0;
        if (!reset_i) begin
            if (state_q == BURST) req_ready_o[grant_q] = 1'b1;
            mac_clr_o   = (state_q == CLEAR);
            res_valid_o = (state_q == RESULT);
        end
    end

    // Registered outputs are also masked during reset so they read 0 at once.
    assign mac_a_o        = reset_i ? 8'h00  : mac_a_q;
    assign mac_b_o        = reset_i ? 8'h00  : mac_b_q;
    assign mac_valid_in_o = reset_i ? 1'b0   : mac_vin_q;
    assign res_data_o     = reset_i ? 16'h0  : res_data_q;
    assign res_id_o       = reset_i ? '0     : grant_q;
    assign res_overflow_o = reset_i ? 1'b0   : res_ovf_q;

    // State, grant, operand pipeline, counter and result registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            cnt_q      <= '0;
            mac_a_q    <= '0;
            mac_b_q    <= '0;
            mac_vin_q  <= 1'b0;
            res_data_q <= '0;
            res_ovf_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mac_vin_q <= xfer;
            if ((state_q == IDLE) && pick_found) begin
                grant_q  <= pick_idx;
                rr_ptr_q <= (pick_idx == GW'(NREQ - 1)) ? GW'(0) : pick_idx + GW'(1);
            end
            if (xfer) begin
                mac_a_q <= a_arr[grant_q];
                mac_b_q <= b_arr[grant_q];
            end
            if (state_q == CLEAR) begin
                res_data_q <= '0;
                res_ovf_q  <= 1'b0;
            end else if (cap) begin
                res_data_q <= mac_f_i;
`ifdef MVM_MAC_ARB_OVF_STICKY_EN
                res_ovf_q  <= res_ovf_q | mac_overflow_i;
`else
                res_ovf_q  <= mac_overflow_i;
`endif
            end
        end
    end

endmodule

// File: tb/tb_mvm_mac_arb.sv
// Directed bench for mvm_mac_arb with a 2-stage behavioural MAC model.
// Honours MVM_MAC_ARB_OVF_STICKY_EN when computing the expected overflow flag.
module tb_mvm_mac_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid, req_last, req_ready;
    logic [31:0] req_a, req_b;
    logic [7:0]  mac_a, mac_b;
    logic        mac_valid_in, mac_clr;
    logic [15:0] mac_f;
    logic        mac_valid_out, mac_overflow;
    logic [15:0] res_data;
    logic [1:0]  res_id;
    logic        res_overflow, res_valid, res_ready;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mvm_mac_arb #(.NREQ(4), .OUTW(4)) dut (
        .clk_i(clk), .reset_i(reset),
        .req_valid_i(req_valid), .req_a_i(req_a), .req_b_i(req_b),
        .req_last_i(req_last), .req_ready_o(req_ready),
        .mac_a_o(mac_a), .mac_b_o(mac_b), .mac_valid_in_o(mac_valid_in),
        .mac_clr_o(mac_clr), .mac_f_i(mac_f), .mac_valid_out_i(mac_valid_out),
        .mac_overflow_i(mac_overflow), .res_data_o(res_data), .res_id_o(res_id),
        .res_overflow_o(res_overflow), .res_valid_o(res_valid), .res_ready_i(res_ready)
    );

    // Behavioural MAC: multiply stage, then accumulate stage. Overflow is
    // injected per element index of the current job via ovf_mask.
    logic [3:0]         ovf_mask;
    logic               s1_v, s1_o, out_v, out_o;
    logic signed [15:0] s1_p, acc;
    logic [2:0]         elem;

    always @(posedge clk) begin
        if (reset) begin
            s1_v <= 1'b0; s1_o <= 1'b0; out_v <= 1'b0; out_o <= 1'b0;
            acc <= '0; elem <= '0; s1_p <= '0;
        end else begin
            s1_v  <= mac_valid_in;
            s1_p  <= $signed(mac_a) * $signed(mac_b);
            s1_o  <= mac_valid_in ? ovf_mask[elem[1:0]] : 1'b0;
            out_v <= s1_v;
            out_o <= s1_o;
            if (mac_clr) begin
                acc  <= '0;
                elem <= '0;
            end else begin
                if (s1_v) acc <= acc + s1_p;
                if (mac_valid_in) elem <= elem + 3'd1;
            end
        end
    end
    assign mac_f         = acc;
    assign mac_valid_out = out_v;
    assign mac_overflow  = out_o;

    // Monitor: issue/clear counters, clear-before-issue ordering, result log.
    int          clr_total = 0, vin_total = 0, order_err = 0;
    logic        clr_seen = 1'b0;
    logic [1:0]  res_id_q[$];
    logic [15:0] res_data_q[$];

    always @(negedge clk) begin
        if (reset) begin
            clr_seen <= 1'b0;
        end else begin
            if (mac_clr) begin
                clr_total <= clr_total + 1;
                clr_seen  <= 1'b1;
            end
            if (mac_valid_in) begin
                vin_total <= vin_total + 1;
                if (!clr_seen) order_err <= order_err + 1;
            end
            if (res_valid && res_ready) begin
                clr_seen <= 1'b0;
                res_id_q.push_back(res_id);
                res_data_q.push_back(res_data);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          rq;
        int          n;
        logic [3:0][7:0] a;
        logic [3:0][7:0] b;
        logic [15:0] exp_data;
        logic [3:0]  ovf_mask;
        logic        exp_ovf;
        int          stall_at;
        int          hold;
    } job_t;

    job_t jobs[5];

    task automatic run_job(input job_t jb);
        int  clr_b, vin_b, ord_b;
        logic acc_ok;
        logic got;
        clr_b    = clr_total;
        vin_b    = vin_total;
        ord_b    = order_err;
        ovf_mask = jb.ovf_mask;
        for (int k = 0; k < jb.n; k++) begin
            if (k == jb.stall_at) begin
                req_valid[jb.rq] = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    if (s > 0) chk("stall_no_issue", {31'd0, mac_valid_in}, 32'd0);
                    chk("stall_grant_held", {31'd0, req_ready[jb.rq]}, 32'd1);
                    @(posedge clk); #1;
                end
            end
            req_a[8*jb.rq +: 8] = jb.a[k];
            req_b[8*jb.rq +: 8] = jb.b[k];
            req_valid[jb.rq]    = 1'b1;
            req_last[jb.rq]     = (k == jb.n - 1);
            acc_ok = 1'b0;
            for (int t = 0; t < 50 && !acc_ok; t++) begin
                @(negedge clk);
                if (req_ready[jb.rq]) acc_ok = 1'b1;
                @(posedge clk); #1;
            end
            chk("element_accept", {31'd0, acc_ok}, 32'd1);
        end
        req_valid[jb.rq] = 1'b0;
        req_last[jb.rq]  = 1'b0;
        got = 1'b0;
        for (int t = 0; t < 60 && !got; t++) begin
            @(negedge clk);
            if (res_valid) got = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk("res_valid_seen", {31'd0, got}, 32'd1);
        chk("res_data", {16'd0, res_data}, {16'd0, jb.exp_data});
        chk("res_id", {30'd0, res_id}, jb.rq);
        chk("res_overflow", {31'd0, res_overflow}, {31'd0, jb.exp_ovf});
        chk("clr_once", clr_total - clr_b, 32'd1);
        chk("issue_count", vin_total - vin_b, jb.n);
        chk("clr_before_issue", order_err - ord_b, 32'd0);
        for (int h = 0; h < jb.hold; h++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("hold_valid", {31'd0, res_valid}, 32'd1);
            chk("hold_data", {16'd0, res_data}, {16'd0, jb.exp_data});
            chk("hold_id", {30'd0, res_id}, jb.rq);
            chk("hold_no_grant", {27'd0, req_ready, mac_clr}, 32'd0);
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        @(negedge clk);
        chk("res_valid_pulse", {31'd0, res_valid}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc_ok;
        int   t;

        // Vector table: requester, length, operands, expected result.
        jobs[0] = '{rq:1, n:3, a:{8'd0, 8'd3, 8'd2, 8'd1}, b:{8'd0, 8'd6, 8'd5, 8'd4},
                    exp_data:16'd32, ovf_mask:4'b0000, exp_ovf:1'b0, stall_at:-1, hold:0};
        // -5 * 7 = -35
        jobs[1] = '{rq:2, n:1, a:{8'd0, 8'd0, 8'd0, 8'hFB}, b:{8'd0, 8'd0, 8'd0, 8'd7},
                    exp_data:16'hFFDD, ovf_mask:4'b0000, exp_ovf:1'b0, stall_at:-1, hold:0};
        // (10,-20,30,-40).(3,3,3,3) = -60, with a 3-cycle stall and a 5-cycle hold
        jobs[2] = '{rq:0, n:4, a:{8'hD8, 8'd30, 8'hEC, 8'd10}, b:{8'd3, 8'd3, 8'd3, 8'd3},
                    exp_data:16'hFFC4, ovf_mask:4'b0000, exp_ovf:1'b0, stall_at:2, hold:5};
        // 127*127*2 = 32258
        jobs[3] = '{rq:3, n:2, a:{8'd0, 8'd0, 8'd127, 8'd127}, b:{8'd0, 8'd0, 8'd127, 8'd127},
                    exp_data:16'd32258, ovf_mask:4'b0000, exp_ovf:1'b0, stall_at:-1, hold:0};
        // Overflow flagged on the middle element only
        jobs[4] = '{rq:1, n:3, a:{8'd0, 8'd1, 8'd1, 8'd1}, b:{8'd0, 8'd1, 8'd1, 8'd1},
                    exp_data:16'd3, ovf_mask:4'b0010, exp_ovf:1'b0, stall_at:-1, hold:0};
`ifdef MVM_MAC_ARB_OVF_STICKY_EN
        jobs[4].exp_ovf = 1'b1;
`endif

        reset = 1'b1; req_valid = '0; req_last = '0; req_a = '0; req_b = '0;
        res_ready = 1'b0; ovf_mask = '0;
        @(negedge clk);
        chk("rst_outputs", {4'd0, req_ready, mac_a, mac_b, mac_valid_in, mac_clr,
                            res_valid, res_overflow, 2'd0}, 32'd0);
        chk("rst_result", {14'd0, res_id, res_data}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("idle_no_ready", {28'd0, req_ready}, 32'd0);

        for (int j = 0; j < 5; j++) run_job(jobs[j]);

        // Reset in the middle of a burst from requester 3.
        req_a[31:24] = 8'd5; req_b[31:24] = 8'd5;
        req_valid[3] = 1'b1; req_last[3] = 1'b0;
        acc_ok = 1'b0;
        for (int k = 0; k < 50 && !acc_ok; k++) begin
            @(negedge clk);
            if (req_ready[3]) acc_ok = 1'b1;
            @(posedge clk); #1;
        end
        chk("midburst_accept", {31'd0, acc_ok}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_outputs", {4'd0, req_ready, mac_a, mac_b, mac_valid_in, mac_clr,
                               res_valid, res_overflow, 2'd0}, 32'd0);
        chk("midrst_result", {14'd0, res_id, res_data}, 32'd0);
        req_valid = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // All four requesters continuously valid with single-element jobs.
        res_id_q.delete();
        res_data_q.delete();
        req_a = {8'd4, 8'd3, 8'd2, 8'd1};
        req_b = {8'd2, 8'd2, 8'd2, 8'd2};
        req_last = 4'hF; req_valid = 4'hF; res_ready = 1'b1; ovf_mask = '0;
        t = 0;
        while (res_id_q.size() < 5 && t < 300) begin
            @(negedge clk);
            @(posedge clk); #1;
            t++;
        end
        req_valid = '0; req_last = '0; res_ready = 1'b0;
        chk("rr_result_count", (res_id_q.size() >= 5) ? 32'd1 : 32'd0, 32'd1);
        if (res_id_q.size() >= 5) begin
            for (int i = 0; i < 5; i++) begin
                chk("rr_grant_order", {30'd0, res_id_q[i]}, i % 4);
                chk("rr_data", {16'd0, res_data_q[i]}, 2 * ((i % 4) + 1));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mvm_mac_arb.md
MVM_MAC_ARB -- requirements
Module: mvm_mac_arb

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one MAC; legal range 2..8.
REQ-002 Parameter OUTW, default 4: width of the outstanding-element counter; the MAC pipeline depth SHALL be below 2**OUTW.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  NREQ  per-requester element valid.
REQ-006 req_a  input  NREQ*8  per-requester signed matrix operand; slice i is [8i+7:8i].
REQ-007 req_b  input  NREQ*8  per-requester signed vector operand; same slicing as req_a.
REQ-008 req_last  input  NREQ  marks the final element of a dot product.
REQ-009 req_ready  output  NREQ  per-requester element accept.
REQ-010 mac_a, mac_b  output  8 each  signed operands to the shared MAC.
REQ-011 mac_valid_in  output  1  operand valid to the MAC.
REQ-012 mac_clr  output  1  one-cycle accumulator clear to the MAC.
REQ-013 mac_f  input  16  signed MAC accumulator output.
REQ-014 mac_valid_out  input  1  mac_f valid.
REQ-015 mac_overflow  input  1  MAC overflow flag, qualified by mac_valid_out.
REQ-016 res_data  output  16  final signed dot product.
REQ-017 res_id  output  $clog2(NREQ)  index of the requester that owns res_data.
REQ-018 res_overflow  output  1  overflow status of the result.
REQ-019 res_valid / res_ready  output / input  1 each  result handshake.

Function
REQ-020 FSM states: IDLE, CLEAR, BURST, DRAIN, RESULT.
REQ-021 IDLE: if any req_valid is high, the arbiter SHALL latch a grant index g by round-robin and move to CLEAR; otherwise it stays in IDLE.
REQ-022 Round-robin: the search starts at (last granted + 1) mod NREQ; after reset the search starts at 0.
REQ-023 CLEAR: mac_clr SHALL be 1 for exactly this one cycle; the FSM then moves to BURST.
REQ-024 BURST: req_ready[g] = 1 and all other req_ready bits = 0; req_ready is combinational from state and g, and is 0 in every other state.
REQ-025 An element transfers when req_valid[g] and req_ready[g] are both high in the same cycle.
REQ-026 On a transfer, mac_a/mac_b are loaded from slice g and mac_valid_in = 1 in the next cycle (one register stage); in cycles with no transfer, mac_valid_in = 0 and mac_a/mac_b hold their values.
REQ-027 If req_valid[g] drops mid-burst, the block stalls with no MAC issue; the grant is held and there is no timeout.
REQ-028 A transfer with req_last[g] = 1 moves the FSM to DRAIN; a single-element burst is legal.
REQ-029 Outstanding counter: +1 on mac_valid_in, -1 on mac_valid_out, unchanged when both occur in the same cycle; mac_valid_out at count 0 is ignored with no underflow.
REQ-030 Every counted mac_valid_out in BURST or DRAIN SHALL capture mac_f into the res_data register.
REQ-031 DRAIN to RESULT when the counter is 0 and mac_valid_in is 0; res_valid = 1 from the first RESULT cycle.
REQ-032 RESULT: res_data, res_id and res_overflow SHALL hold stable while res_valid = 1 and res_ready = 0.
REQ-033 RESULT to IDLE in the cycle after res_valid and res_ready are both high; a new grant is possible from that IDLE cycle.
REQ-034 Exactly one dot product is in flight; requests arriving during a burst wait and are never dropped.

Reset
REQ-035 While reset is high, every output SHALL be 0: req_ready, mac_a, mac_b, mac_valid_in, mac_clr, res_data, res_id, res_overflow, res_valid.
REQ-036 While reset is high: FSM = IDLE, round-robin pointer = 0, outstanding counter = 0.
REQ-037 Reset mid-burst abandons the job with no result emitted; the requester SHALL resend the whole vector.

Configuration
REQ-038 Macro MVM_MAC_ARB_OVF_STICKY_EN defined: res_overflow = OR of mac_overflow over all counted mac_valid_out of the job, cleared in CLEAR.
REQ-039 Macro MVM_MAC_ARB_OVF_STICKY_EN undefined: res_overflow = mac_overflow sampled with the last captured mac_f.

Verification
REQ-040 Requester 1 sends a=(1,2,3) and b=(4,5,6) against a 2-stage MAC -> res_data=32, res_id=1, res_valid pulse, mac_clr seen exactly once before the first mac_valid_in.
REQ-041 req_valid=4'b1111 held over 4 jobs -> grant order 0,1,2,3; a 5th job -> requester 0 again.
REQ-042 Requester 2 sends a single element a=-5, b=7 with last=1 -> res_data=-35, res_id=2.
REQ-043 req_valid[g] deasserted for 3 cycles mid-burst -> no mac_valid_in in those cycles and the final result is unchanged; res_ready held 0 for 5 cycles -> outputs stable and no new grant.
REQ-044 Overflow on the middle element only, with the macro on vs off -> res_overflow=1 vs 0.
REQ-045 Reset asserted mid-burst -> all outputs 0 next cycle and the next grant goes to the lowest-index active requester.
